// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the multi-cycle shift sequencer.
package shift_defs;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_LUI = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // LUI is a fixed left shift by half a word; shamt is ignored.
  localparam logic [5:0] LUI_AMOUNT = 6'd16;

endpackage

// File: rtl/shift_sequencer_step.sv
// One bounded shift step: moves the word by k (0..STEP) bits.
// SRA fills from the sign bit latched at accept, not from the live word.
module shift_step
  import shift_defs::*;
#(
  parameter int STEP  = 4,
  parameter int WIDTH = 32,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_in,
  input  op_e              op,
  input  logic             sign,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] wide;

  // Select shift direction and fill per op; LUI behaves as SLL.
  always_comb begin
    wide   = {{WIDTH{sign}}, data_in} >> k;
    result = data_in << k;
    case (op)
      OP_SRL:  result = data_in >> k;
      OP_SRA:  result = wide[WIDTH-1:0];
      default: result = data_in << k;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: iterates shift_step until the requested
// amount has been applied, then pulses done for one cycle.
// Optional flush input is enabled by defining SHIFT_SEQ_ABORT_EN.
module shift_sequencer
  import shift_defs::*;
#(
  parameter int STEP  = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] data_in,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int KW = $clog2(STEP + 1);

  state_e           state;
  op_e              op_r;
  logic             sign_r;
  logic [5:0]       remaining;
  logic [WIDTH-1:0] work;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] stepped;
  logic [5:0]       load_cnt;
  logic             can_accept;
  logic             accept;
  logic             flush;

  assign can_accept = (state == S_IDLE) || (state == S_DONE);
  assign load_cnt   = (op_e'(op) == OP_LUI) ? LUI_AMOUNT : {1'b0, shamt};

`ifdef SHIFT_SEQ_ABORT_EN
  // Flush wins over a new request, including start in IDLE.
  assign flush  = abort && (state != S_IDLE);
  assign accept = start && !abort && can_accept;
`else
  assign flush  = 1'b0;
  assign accept = start && can_accept;
`endif

  // Step size this cycle: the remainder, capped at STEP.
  always_comb begin
    k = KW'(STEP);
    if (remaining < 6'(STEP)) k = KW'(remaining);
  end

  shift_step #(.STEP(STEP), .WIDTH(WIDTH)) u_step (
    .data_in (work),
    .op      (op_r),
    .sign    (sign_r),
    .k       (k),
    .result  (stepped)
  );

  // FSM, counter and working register; done is registered with the
  // transition into DONE so it is high exactly for the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_r      <= OP_SLL;
      sign_r    <= 1'b0;
      remaining <= '0;
      work      <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else if (accept) begin
        work      <= data_in;
        op_r      <= op_e'(op);
        sign_r    <= data_in[WIDTH-1];
        remaining <= load_cnt;
        if (load_cnt == 6'd0) begin
          state <= S_DONE;
          done  <= 1'b1;
        end else begin
          state <= S_SHIFT;
        end
      end else begin
        case (state)
          S_SHIFT: begin
            work      <= stepped;
            remaining <= remaining - 6'(k);
            if (remaining == 6'(k)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy   = (state == S_SHIFT);
  assign result = work;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller for variable-amount shifts (sll/srl/sra/lui class).
- Iterates a bounded step shifter over several cycles instead of instantiating a full 32-bit barrel shifter.
- Sits beside the ALU in the EX stage.
- busy stalls the pipeline; done/result return the shifted word to EX.

Parameters:
STEP, 4, maximum bits shifted per cycle (power of two, 1..16)
WIDTH, 32, data width (fixed 32 for this core)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE or DONE
op  in  2  00=SLL, 01=SRL, 10=SRA, 11=LUI (shift left 16, shamt ignored)
shamt  in  5  shift amount, 0..31
data_in  in  32  operand, captured on accept
busy  out  1  high while in SHIFT
done  out  1  one-cycle pulse, result valid
result  out  32  shifted word, held until next accept

Behaviour:
- Reset (synchronous): state=IDLE, busy=0, done=0, result=0, remaining count=0. Reset mid-SHIFT aborts the operation with no done pulse.
- States: IDLE, SHIFT, DONE.
- Accept: start=1 in IDLE or DONE at a clock edge.
  - Loads data_in into the working register (drives result), op into the op register, and the remaining count.
  - Remaining count = shamt, or 16 for LUI.
  - Next state: SHIFT if count != 0, else DONE.
- SHIFT, each edge:
  - k = min(remaining, STEP).
  - Working register shifted by k: SLL zero-fill left; SRL zero-fill right; SRA sign-fill right, using the bit 31 captured at accept; LUI as SLL.
  - remaining -= k.
  - If the new remaining == 0, go to DONE; otherwise stay in SHIFT.
  - start is ignored in SHIFT.
- DONE: done=1 for exactly this one cycle.
  - start=1 is accepted (back-to-back issue), with the same rules as IDLE.
  - Otherwise go to IDLE. done must never be high for two consecutive cycles unless a new op was accepted.
- Latency from the accept edge to the done-high cycle is ceil(count/STEP)+1 cycles:
  - shamt=0: 1 cycle.
  - shamt=31, STEP=4: 9 cycles.
  - LUI, STEP=4: 5 cycles.
- busy = (state==SHIFT). busy is combinational from state only, with no path from start.
- result shows intermediate values while busy; it is valid only with done and stays stable until the next accept.
- Shift amounts are never reduced modulo width. SRA by 31 of a negative value yields 0xFFFFFFFF.

Optional Feature:
SHIFT_SEQ_ABORT_EN
- Defined: adds input abort (1 bit, for pipeline flush).
  - abort=1 in SHIFT or DONE returns to IDLE next edge: no done pulse, result unchanged from the abort cycle.
  - abort=1 together with start in IDLE gives abort priority: the request is not accepted.
- Undefined: no abort port; behaviour as above.

Decomposition:
- Shared package shift_defs:
  - op encodings (OP_SLL, OP_SRL, OP_SRA, OP_LUI).
  - state encodings (S_IDLE, S_SHIFT, S_DONE).
  - LUI_AMOUNT = 16.
- One natural sub-module, shift_step: combinational, shifts 32 bits by k (0..STEP) per op with sign fill. The sequencer holds the FSM, counter and registers.

Test Plan:
1. reset high for 2 cycles mid-SHIFT (SLL 0x1 by 31) -> state IDLE, busy=0, done=0, result=0; no done pulse afterwards.
2. SLL data_in=0x00000001 shamt=31, STEP=4 -> busy high 8 cycles; done on cycle 9 after accept; result=0x80000000.
3. SRA data_in=0x80000000 shamt=4 -> done 2 cycles after accept, result=0xF8000000. SRL same input -> 0x08000000.
4. LUI data_in=0x00001234 shamt=7 (ignored) -> result=0x12340000 after 5 cycles. shamt=0 SLL 0xDEADBEEF -> done next cycle, result=0xDEADBEEF, busy never high.
5. Back-to-back: start held high through DONE with new op SRL 0xF0000000 shamt=8 -> second op accepted in the DONE cycle; done pulses once per op; start pulses during SHIFT are ignored.
6. With SHIFT_SEQ_ABORT_EN: abort in the 3rd SHIFT cycle of SLL by 20 -> IDLE next edge, no done pulse, next start accepted normally.
